usb_crc_append: RTL and testbench
=================================

# usb_crc_append

Parametrised CRC-append stage of the USB transmit path, sitting between the bit-stream encoder and the bit stuffer. It accepts a serial packet stream (SYNC+PID header followed by payload) and buffers it in a tagged bit FIFO. It computes CRC5 for token packets or CRC16 for data packets on the fly over the payload bits only, and appends the complemented CRC. The output is a serial stream with first/last markers, and the bit stuffer can pause it on any cycle.

## Interface
- DEPTH, 32: FIFO depth in bits; power of two, ≥8.
- HDR_BITS, 16: leading bits per packet (SYNC+PID) passed through and excluded from CRC.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_in  in  1  serial data bit, wire order.
- s_valid  in  1  s_in/s_last/pkt_in valid this cycle.
- s_last  in  1  marks final upstream bit of packet (CRC not included).
- pkt_in  in  2  packet type, sampled with the first bit: 01 token (CRC5), 11 data (CRC16), 10 handshake or 00 raw (no CRC).
- s_ready  out  1  bit accepted when s_valid && s_ready.
- pause  in  1  bit stuffer stall; output bit held while high.
- s_out  out  1  current output bit (FIFO head).
- out_valid  out  1  FIFO non-empty; bit consumed when out_valid && !pause.
- start_b  out  1  high while the head bit is a packet's first bit.
- endb  out  1  high while the head bit is a packet's last bit.
- busy  out  1  input FSM not IDLE, or FIFO non-empty.

## Operation
- FIFO entries are {first, last, bit}; count is $clog2(DEPTH)+1 bits, and read and write pointers wrap modulo DEPTH.
- Input FSM states:
  - IDLE: on accept, latch pkt_in, write the bit with first=1, hcnt=1, go HDR.
  - HDR: pass-through bits, hcnt++ per accept; after HDR_BITS bits go BODY.
  - BODY: each accepted bit is written to the FIFO and shifted into the selected CRC.
  - CRC: write the CRC bits one per cycle.
- s_last on an accepted bit, in any state:
  - type 10 or 00: write that bit with last=1, go IDLE.
  - type 01 or 11: go CRC, even if still in HDR; the CRC then covers zero payload bits.
  - s_last on the very first bit sets first=1 and last=1 on the same entry.
- CRC5: poly x^5+x^2+1, init 11111. Per bit: fb=in^crc[4]; crc={crc[3:0],0}^(fb?00101:0).
- CRC16: poly x^16+x^15+x^2+1, init FFFF, same serial form with mask 8005h.
- CRC state writes ~crc MSB first (bit 4 or bit 15 first), one bit per cycle while not full. The last CRC bit is tagged last=1, then the FSM goes IDLE and the CRC register reloads all-ones.
- s_ready = !rst && !full && state!=CRC.
- Write occurs only when count<DEPTH; there is no full-bypass.
- Read occurs when out_valid && !pause.
- Simultaneous read and write: count unchanged, both pointers advance.
- start_b, endb and s_out are combinational from the head entry and are 0 when empty.
- Back-to-back packets are allowed: a new first bit can be accepted the cycle after the FSM returns to IDLE while the previous packet is still draining.

## Timing
- Reset (rst high at an edge): state IDLE, pointers and count 0, CRC registers all-ones.
  - out_valid, start_b, endb, s_out, busy = 0.
  - s_ready = 0 while rst is high.
  - Reset mid-packet discards all buffered and in-flight bits with no endb.
- Latency: a bit accepted at edge N into an empty FIFO appears on s_out after edge N, i.e. 1 cycle.
- The first CRC bit is written at the edge after s_last is accepted. Tail to FIFO costs 5 or 16 cycles when unstalled; s_ready is low during those cycles.
- When pause is held, s_out, start_b and endb are stable and the FIFO fills; s_ready drops when count reaches DEPTH.
- Throughput: 1 bit/cycle in and out with pause low.

## Test plan
- Token, header 16 bits, payload 11 zeros, s_last on the 27th bit, pause=0 -> 32 output bits. Bits 28..32 = 0,1,0,0,0. start_b on bit 1 only, endb on bit 32 only.
- Data packet with an empty payload (s_last on the 16th header bit) -> 16 appended bits all 0; total 32 bits; endb on bit 32.
- Handshake, 16 bits -> identical 16 bits out, no CRC, endb on bit 16; then an immediately following token, checked against a behavioural CRC5 model.
- Random data payloads of 0-64 bytes with random pause at 50% density:
  - output equals input plus the model CRC16;
  - output order is preserved;
  - s_out is stable whenever pause is high;
  - s_ready is low when count==DEPTH and no bits are lost;
  - pointers wrap at least 4×.
- Pause held for 40 cycles with DEPTH=32 -> s_ready=0 once 32 entries are stored; on release, the drain resumes with no dropped or duplicated bits.
- rst pulsed mid-data-payload -> the next cycle has out_valid=0, busy=0, s_ready=0 during rst; a following token is correct, which confirms the CRC was reinitialised.

Source files
------------

// File: rtl/usb_crc_append.sv
// USB transmit CRC-append stage: buffers a tagged serial packet stream and
// appends the complemented CRC5 (token) or CRC16 (data) computed over the payload.
module usb_crc_append #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned HDR_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_in,
  input  logic       s_valid,
  input  logic       s_last,
  input  logic [1:0] pkt_in,
  output logic       s_ready,
  input  logic       pause,
  output logic       s_out,
  output logic       out_valid,
  output logic       start_b,
  output logic       endb,
  output logic       busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = $clog2(HDR_BITS + 1);

  typedef enum logic [1:0] {IDLE, HDR, BODY, CRC} state_t;

  typedef struct packed {
    logic first;
    logic last;
    logic data;
  } entry_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [3:0]      ccnt_q, ccnt_d;
  logic [1:0]      ptype_q, ptype_d;
  logic [4:0]      crc5_q, crc5_d;
  logic [15:0]     crc16_q, crc16_d;
  logic            wr_en;
  entry_t          wr_entry;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty, accept, rd_en, crc_last;
  entry_t          head;

  function automatic logic [4:0] crc5_next(input logic [4:0] c, input logic b);
    logic fb;
    fb = b ^ c[4];
    return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
  endfunction

  function automatic logic [15:0] crc16_next(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign s_ready   = !rst && !full && (state_q != CRC);
  assign accept    = s_valid && s_ready;
  assign out_valid = !empty;
  assign rd_en     = out_valid && !pause;
  assign head      = mem[rd_ptr];
  assign s_out     = !empty && head.data;
  assign start_b   = !empty && head.first;
  assign endb      = !empty && head.last;
  assign busy      = (state_q != IDLE) || !empty;
  assign crc_last  = (ccnt_q == (ptype_q[1] ? 4'd15 : 4'd4));

  // Next-state, CRC update and FIFO write generation.
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    ccnt_d   = ccnt_q;
    ptype_d  = ptype_q;
    crc5_d   = crc5_q;
    crc16_d  = crc16_q;
    wr_en    = 1'b0;
    wr_entry = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ptype_d  = pkt_in;
          wr_en    = 1'b1;
          wr_entry = '{first: 1'b1, last: s_last && !pkt_in[0], data: s_in};
          hcnt_d   = HW'(1);
          if (s_last)              state_d = pkt_in[0] ? CRC : IDLE;
          else if (HDR_BITS <= 1)  state_d = BODY;
          else                     state_d = HDR;
        end
      end
      HDR: begin
        if (accept) begin
          wr_en    = 1'b1;
          wr_entry = '{first: 1'b0, last: s_last && !ptype_q[0], data: s_in};
          hcnt_d   = hcnt_q + HW'(1);
          if (s_last)                             state_d = ptype_q[0] ? CRC : IDLE;
          else if (hcnt_q == HW'(HDR_BITS - 1))   state_d = BODY;
        end
      end
      BODY: begin
        if (accept) begin
          wr_en    = 1'b1;
          wr_entry = '{first: 1'b0, last: s_last && !ptype_q[0], data: s_in};
          if (ptype_q == 2'b01) crc5_d  = crc5_next(crc5_q, s_in);
          if (ptype_q == 2'b11) crc16_d = crc16_next(crc16_q, s_in);
          if (s_last) state_d = ptype_q[0] ? CRC : IDLE;
        end
      end
      CRC: begin
        // Emit ~crc MSB first by shifting the register left one bit per write.
        if (!full) begin
          wr_en    = 1'b1;
          wr_entry = '{first: 1'b0, last: crc_last,
                       data: ptype_q[1] ? ~crc16_q[15] : ~crc5_q[4]};
          crc5_d   = {crc5_q[3:0], 1'b1};
          crc16_d  = {crc16_q[14:0], 1'b1};
          ccnt_d   = ccnt_q + 4'd1;
          if (crc_last) begin
            state_d = IDLE;
            ccnt_d  = '0;
            crc5_d  = '1;
            crc16_d = '1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      ccnt_q  <= '0;
      ptype_q <= '0;
      crc5_q  <= '1;
      crc16_q <= '1;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      ccnt_q  <= ccnt_d;
      ptype_q <= ptype_d;
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
    end
  end

  // Storage array needs no reset: entries are only visible when count is nonzero.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_crc_append.sv
// Randomised self-checking bench for usb_crc_append with a polynomial CRC reference model.
module tb_usb_crc_append;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned HDR   = 16;

  logic       clk = 1'b0;
  logic       rst, s_in, s_valid, s_last, pause, s_ready, s_out, out_valid, start_b, endb, busy;
  logic [1:0] pkt_in;

  int n_checks = 0;
  int n_fail   = 0;
  int pause_mode = 0;
  int stab_err = 0;
  int accepted = 0;
  logic       have_prev = 1'b0;
  logic [2:0] prev;
  logic [2:0] got_q[$];
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  usb_crc_append #(.DEPTH(DEPTH), .HDR_BITS(HDR)) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid), .s_last(s_last),
    .pkt_in(pkt_in), .s_ready(s_ready), .pause(pause), .s_out(s_out),
    .out_valid(out_valid), .start_b(start_b), .endb(endb), .busy(busy)
  );

  // Stall generator: off, 50% random, or held.
  always @(posedge clk) begin
    #2;
    case (pause_mode)
      0:       pause = 1'b0;
      1:       pause = 1'($urandom_range(0, 1));
      default: pause = 1'b1;
    endcase
  end

  // Output collector and stall-stability watcher, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      if (out_valid && have_prev && ({start_b, endb, s_out} !== prev)) stab_err++;
      have_prev = out_valid && pause;
      prev = {start_b, endb, s_out};
      if (out_valid && !pause) got_q.push_back({start_b, endb, s_out});
      if (s_valid && s_ready) accepted++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: stream passes through unchanged, then ~remainder of payload over the generator.
  function automatic void model_pkt(input logic [1:0] t, input logic bq[$]);
    int n = bq.size();
    int width, poly, mask, crc, fb;
    for (int i = 0; i < n; i++) exp_q.push_back({1'(i == 0), 1'((i == n - 1) && !t[0]), bq[i]});
    if (t[0]) begin
      width = t[1] ? 16 : 5;
      poly  = t[1] ? 32'h8005 : 32'h0005;
      mask  = (1 << width) - 1;
      crc   = mask;
      for (int i = HDR; i < n; i++) begin
        fb  = int'(bq[i]) ^ ((crc >> (width - 1)) & 1);
        crc = ((crc << 1) ^ (fb != 0 ? poly : 0)) & mask;
      end
      for (int k = width - 1; k >= 0; k--)
        exp_q.push_back({1'b0, 1'(k == 0), 1'(~((crc >> k) & 1))});
    end
  endfunction

  task automatic send_bits(input logic [1:0] t, input logic bq[$], input bit term,
                           input int gap_pct, output bit ok);
    ok = 1'b1;
    foreach (bq[i]) begin
      int tries = 0;
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1; s_in = bq[i]; pkt_in = t;
      s_last  = term && (i == bq.size() - 1);
      forever begin
        @(negedge clk);
        if (s_ready) break;
        tries++;
        if (tries > 2000) begin ok = 1'b0; break; end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      if (!ok) break;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_in = 1'b0; s_last = 1'b0; pkt_in = 2'b00;
    repeat (3) @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (start_b !== 1'b0)   begin n_fail++; $display("FAIL reset_start_b: got %b want 0", start_b); end
    n_checks++; if (endb !== 1'b0)      begin n_fail++; $display("FAIL reset_endb: got %b want 0", endb); end
    n_checks++; if (s_out !== 1'b0)     begin n_fail++; $display("FAIL reset_s_out: got %b want 0", s_out); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (s_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_checks++; if (s_ready !== 1'b1)   begin n_fail++; $display("FAIL post_reset_s_ready: got %b want 1", s_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    pause_mode = 0;
    s_valid = 1'b1; s_in = 1'b1; s_last = 1'b1; pkt_in = 2'b00;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_pre_valid: got %b want 0", out_valid); end
    @(posedge clk); #1; s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, start_b, endb, s_out} !== 4'b1111) begin
      n_fail++; $display("FAIL lat_single_bit: got %b want 1111", {out_valid, start_b, endb, s_out});
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lat_drained_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    got_q.delete();
  endtask

  task automatic test_token_zero();
    logic b[$];
    logic [2:0] e[$];
    logic [4:0] tail = 5'b01000;
    bit ok;
    got_q.delete(); pause_mode = 0;
    for (int i = 0; i < 16; i++) b.push_back(1'($urandom));
    for (int i = 0; i < 11; i++) b.push_back(1'b0);
    for (int i = 0; i < 27; i++) e.push_back({1'(i == 0), 1'b0, b[i]});
    for (int k = 4; k >= 0; k--) e.push_back({1'b0, 1'(k == 0), tail[k]});
    send_bits(2'b01, b, 1'b1, 0, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tok_send: got %b want 1", ok); end
    wait_idle(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tok_drain: got %b want 1", ok); end
    n_checks++;
    if (got_q.size() !== e.size()) begin n_fail++; $display("FAIL tok_len: got %0d want %0d", got_q.size(), e.size()); end
    for (int i = 0; i < e.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== e[i]) begin n_fail++; $display("FAIL tok_bit[%0d]: got %b want %b", i, got_q[i], e[i]); end
    end
  endtask

  task automatic test_data_empty();
    logic b[$];
    logic [2:0] e[$];
    bit ok;
    got_q.delete(); pause_mode = 0;
    for (int i = 0; i < 16; i++) b.push_back(1'($urandom));
    for (int i = 0; i < 16; i++) e.push_back({1'(i == 0), 1'b0, b[i]});
    for (int i = 0; i < 16; i++) e.push_back({1'b0, 1'(i == 15), 1'b0});
    send_bits(2'b11, b, 1'b1, 0, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL empty_send: got %b want 1", ok); end
    wait_idle(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL empty_drain: got %b want 1", ok); end
    n_checks++;
    if (got_q.size() !== e.size()) begin n_fail++; $display("FAIL empty_len: got %0d want %0d", got_q.size(), e.size()); end
    for (int i = 0; i < e.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== e[i]) begin n_fail++; $display("FAIL empty_bit[%0d]: got %b want %b", i, got_q[i], e[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic hs[$], tk[$], raw[$];
    bit ok1, ok2, ok3, ok4;
    got_q.delete(); exp_q.delete(); pause_mode = 0;
    for (int i = 0; i < 16; i++) hs.push_back(1'($urandom));
    for (int i = 0; i < 27; i++) tk.push_back(1'($urandom));
    raw.push_back(1'b1);
    model_pkt(2'b10, hs); model_pkt(2'b01, tk); model_pkt(2'b00, raw);
    send_bits(2'b10, hs, 1'b1, 0, ok1);
    send_bits(2'b01, tk, 1'b1, 0, ok2);
    send_bits(2'b00, raw, 1'b1, 0, ok3);
    wait_idle(ok4);
    n_checks++;
    if ({ok1, ok2, ok3, ok4} !== 4'b1111) begin n_fail++; $display("FAIL b2b_flow: got %b want 1111", {ok1, ok2, ok3, ok4}); end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_bit[%0d]: got %b want %b", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_data();
    bit ok, all_ok;
    got_q.delete(); exp_q.delete(); stab_err = 0; all_ok = 1'b1;
    pause_mode = 1;
    for (int p = 0; p < 8; p++) begin
      logic b[$];
      int nbytes = (p == 0) ? $urandom_range(16, 64) : $urandom_range(0, 64);
      for (int i = 0; i < HDR + nbytes * 8; i++) b.push_back(1'($urandom));
      model_pkt(2'b11, b);
      send_bits(2'b11, b, 1'b1, 20, ok);
      all_ok &= ok;
    end
    wait_idle(ok);
    all_ok &= ok;
    pause_mode = 0;
    n_checks++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL rnd_flow: got %b want 1", all_ok); end
    n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL rnd_pause_stable: got %0d changes want 0", stab_err); end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_bit[%0d]: got %b want %b", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_pause_hold();
    logic b[$];
    bit ok, ok2;
    got_q.delete(); exp_q.delete(); stab_err = 0;
    pause_mode = 2;
    @(posedge clk); #1;
    accepted = 0;
    for (int i = 0; i < 64; i++) b.push_back(1'($urandom));
    model_pkt(2'b11, b);
    fork
      send_bits(2'b11, b, 1'b1, 0, ok);
      begin
        repeat (40) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL hold_s_ready: got %b want 0", s_ready); end
        n_checks++; if (accepted !== 32) begin n_fail++; $display("FAIL hold_accepted: got %0d want 32", accepted); end
        n_checks++;
        if ({out_valid, start_b} !== 2'b11) begin n_fail++; $display("FAIL hold_head: got %b want 11", {out_valid, start_b}); end
        @(posedge clk); #1;
        pause_mode = 0;
      end
    join
    wait_idle(ok2);
    n_checks++; if ({ok, ok2} !== 2'b11) begin n_fail++; $display("FAIL hold_flow: got %b want 11", {ok, ok2}); end
    n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL hold_stable: got %0d changes want 0", stab_err); end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL hold_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL hold_bit[%0d]: got %b want %b", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic d[$], tk[$], dt[$];
    bit ok, ok2, ok3;
    pause_mode = 1;
    for (int i = 0; i < HDR + 40; i++) d.push_back(1'($urandom));
    send_bits(2'b11, d, 1'b0, 0, ok);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_s_ready: got %b want 0", s_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0; pause_mode = 0;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < HDR + 11; i++) tk.push_back(1'($urandom));
    for (int i = 0; i < HDR + 24; i++) dt.push_back(1'($urandom));
    model_pkt(2'b01, tk); model_pkt(2'b11, dt);
    send_bits(2'b01, tk, 1'b1, 0, ok2);
    send_bits(2'b11, dt, 1'b1, 0, ok3);
    ok2 &= ok3;
    wait_idle(ok3);
    n_checks++; if ({ok, ok2, ok3} !== 3'b111) begin n_fail++; $display("FAIL rstmid_flow: got %b want 111", {ok, ok2, ok3}); end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rstmid_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_bit[%0d]: got %b want %b", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_token_zero();
    test_data_empty();
    test_back_to_back();
    test_random_data();
    test_pause_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
